// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the LCD parallel-bus controller.
package lcd_bus_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } lcd_state_e;

    // Avalon register map
    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_CHAR   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_FULL  = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_LEVEL = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_OVF_CLR = 2;

    // Commands that need the long settle time (clear display, return home)
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

endpackage

// File: rtl/lcd_bus_fifo.sv
// Synchronous byte FIFO with flush; pointers carry an extra MSB so level
// distinguishes full from empty. Pushes while full and pushes during flush
// are dropped here; the caller decides how to flag them.
module lcd_bus_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_level_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_level   = r_wptr - r_rptr;
    assign o_level_c = w_level;
    assign o_full_c  = (w_level == LW'(DEPTH));
    assign o_empty_c = (w_level == '0);
    assign o_rdata_c = r_mem[r_rptr[AW-1:0]];

    assign w_do_push = i_push & ~o_full_c & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty_c & ~i_flush;

    // Pointer update; flush empties the FIFO by catching read up to write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// Avalon-MM slave that queues LCD command/character bytes and replays them
// on an HD44780-style 8-bit bus with programmable setup/pulse/hold/settle.
// Optional feature macro: LCD_BUS_CTRL_IRQ_EN (drain-complete interrupt).
module lcd_bus_ctrl
    import lcd_bus_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned PULSE_CYC    = 12,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned GAP_CYC      = 2000,
    parameter int unsigned LONG_GAP_CYC = 82000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [15:0]       readdata,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(LONG_GAP_CYC + 1);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW    = DATA_W + 1;

    lcd_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_lcd_e;
    logic              r_lcd_rs;
    logic [DATA_W-1:0] r_lcd_data;
    logic              r_ovf;

    logic              w_wr;
    logic              w_push;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_ovf_clr;
    logic              w_pop;
    logic              w_long;
    logic [FW-1:0]     w_rdata;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;

    assign w_wr      = chipselect & ~write_n;
    assign w_push    = w_wr & ((address == ADDR_CMD) | (address == ADDR_CHAR));
    assign w_ctrl_wr = w_wr & (address == ADDR_CTRL);
    assign w_flush   = w_ctrl_wr & writedata[CTRL_FLUSH];
    assign w_ovf_clr = w_ctrl_wr & writedata[CTRL_OVF_CLR];
    assign w_pop     = (r_state == ST_IDLE) & ~w_empty & ~w_flush;

    // Clear and home commands need the long settle; characters never do
    assign w_long = ~r_lcd_rs & ((r_lcd_data == DATA_W'(OP_CLEAR)) |
                                 (r_lcd_data == DATA_W'(OP_HOME))  |
                                 (r_lcd_data == DATA_W'(OP_HOME_ALT)));

    lcd_bus_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wdata   ({(address == ADDR_CHAR), writedata}),
        .o_rdata_c (w_rdata),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_level_c (w_level)
    );

    // Sticky overflow: a push that finds the FIFO full (flush suppresses it)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_push & w_full & ~w_flush) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Transfer sequencer: one down-counter reloaded with N-1 on every state entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_SETUP;
                        r_cnt      <= CNT_W'(SETUP_CYC - 1);
                        r_lcd_rs   <= w_rdata[DATA_W];
                        r_lcd_data <= w_rdata[DATA_W-1:0];
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_PULSE;
                        r_cnt   <= CNT_W'(PULSE_CYC - 1);
                        r_lcd_e <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= CNT_W'(HOLD_CYC - 1);
                        r_lcd_e <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= w_long ? CNT_W'(LONG_GAP_CYC - 1) : CNT_W'(GAP_CYC - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_lcd_e <= 1'b0;
                end
            endcase
        end
    end

`ifdef LCD_BUS_CTRL_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // Interrupt enable and level interrupt on drain complete
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= writedata[CTRL_IRQ_EN];
            r_irq <= r_irq_en & w_empty & (r_state == ST_IDLE);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Zero-wait register read, no side effects
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: begin
                readdata[STAT_BUSY]            = (r_state != ST_IDLE);
                readdata[STAT_EMPTY]           = w_empty;
                readdata[STAT_FULL]            = w_full;
                readdata[STAT_OVF]             = r_ovf;
                readdata[STAT_LEVEL +: LVL_W]  = w_level;
            end
`ifdef LCD_BUS_CTRL_IRQ_EN
            ADDR_CTRL: begin
                readdata[CTRL_IRQ_EN] = r_irq_en;
            end
`endif
            default: begin
                readdata = '0;
            end
        endcase
    end

    assign lcd_e    = r_lcd_e;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_data = r_lcd_data;
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Self-checking bench for lcd_bus_ctrl: register table, directed timing
// sequences, and randomized traffic against a queue-based transfer model.
module tb_lcd_bus_ctrl;

    localparam int S  = 2;
    localparam int PU = 4;
    localparam int H  = 2;
    localparam int G  = 8;
    localparam int LG = 40;
    localparam int D  = 4;
`ifdef LCD_BUS_CTRL_IRQ_EN
    localparam bit IRQB = 1'b1;
`else
    localparam bit IRQB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [7:0]  writedata = 8'h00;
    logic [15:0] readdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic        irq;

    lcd_bus_ctrl #(
        .DATA_W       (8),
        .FIFO_DEPTH   (D),
        .SETUP_CYC    (S),
        .PULSE_CYC    (PU),
        .HOLD_CYC     (H),
        .GAP_CYC      (G),
        .LONG_GAP_CYC (LG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int       c;
        bit       rs;
        bit [7:0] d;
    } xfer_t;

    xfer_t obs_q[$];
    xfer_t exp_q[$];

    // Bus monitor: records each E rise and checks every completed E width
    bit mon_prev_e = 1'b0;
    int mon_hi = 0;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            mon_prev_e = 1'b0;
            mon_hi = 0;
        end else begin
            if (lcd_e && !mon_prev_e) obs_q.push_back('{c: cyc, rs: lcd_rs, d: lcd_data});
            if (lcd_e) begin
                mon_hi++;
            end else if (mon_prev_e) begin
                chk("e_width", 32'(mon_hi), 32'(PU));
                mon_hi = 0;
            end
            mon_prev_e = lcd_e;
        end
    end

    // Reference model: pending bytes, next edge at which a pop may occur
    bit [8:0] mq[$];
    int next_free  = 0;
    int busy_until = 0;
    bit movf       = 1'b0;

    task automatic model_reset();
        mq.delete();
        next_free  = 0;
        busy_until = 0;
        movf       = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Advance the model across clock edge e
    task automatic model_step(input int e, input bit push, input bit rs, input bit [7:0] d, input bit clr);
        bit       full;
        bit [8:0] ent;
        int       g;
        full = (mq.size() == D);
        if (mq.size() > 0 && e >= next_free) begin
            ent = mq.pop_front();
            exp_q.push_back('{c: e + S, rs: ent[8], d: ent[7:0]});
            g = (!ent[8] && ent[7:0] >= 8'd1 && ent[7:0] <= 8'd3) ? LG : G;
            busy_until = e + S + PU + H + g;
            next_free  = busy_until + 1;
        end
        if (push) begin
            if (full) movf = 1'b1;
            else      mq.push_back({rs, d});
        end
        if (clr) movf = 1'b0;
    endtask

    function automatic logic [15:0] model_status(input int c);
        logic [15:0] s;
        s    = '0;
        s[0] = (c < busy_until);
        s[1] = (mq.size() == 0);
        s[2] = (mq.size() == D);
        s[3] = movf;
        s[6:4] = 3'(mq.size());
        return s;
    endfunction

    // One cycle of modelled traffic: drive, optionally check STATUS, step, advance
    task automatic tick(input bit push, input bit rs, input bit [7:0] d, input bit rd, input bit clr);
        chipselect = push | rd | clr;
        write_n    = !(push | clr);
        address    = push ? {1'b0, rs} : (clr ? 2'd3 : 2'd2);
        writedata  = push ? d : (clr ? 8'h04 : 8'h00);
        #1;
        if (rd) chk("rnd_status", 32'(readdata), 32'(model_status(cyc)));
        model_step(cyc + 1, push, rs, d, clr);
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle_raw(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_raw(input bit [1:0] a, input bit [7:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_status(input string nm, input logic [15:0] exp);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd2;
        #1;
        chk(nm, 32'(readdata), 32'(exp));
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 8'h00;
        reset_n    = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_outputs", 32'({lcd_e, lcd_rs, lcd_rw, irq, lcd_data}), 32'h0);
        reset_n = 1'b1;
        read_status("rst_status", 16'h0002);
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic compare_xfers(input string nm);
        int n;
        chk({nm, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_ecyc"}, 32'(obs_q[i].c), 32'(exp_q[i].c));
            chk({nm, "_byte"}, 32'({obs_q[i].rs, obs_q[i].d}), 32'({exp_q[i].rs, exp_q[i].d}));
        end
    endtask

    typedef struct {
        bit        cs;
        bit        wr;
        bit [1:0]  a;
        bit [7:0]  wd;
        bit        en;
        bit [15:0] exp;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Register-map table: read value is sampled with the row's inputs applied
        tbl[0]  = '{1, 0, 2'd2, 8'h00, 1, 16'h0002};
        tbl[1]  = '{1, 0, 2'd3, 8'h00, 1, 16'h0000};
        tbl[2]  = '{1, 0, 2'd0, 8'h00, 1, 16'h0000};
        tbl[3]  = '{1, 1, 2'd3, 8'h01, 1, 16'h0000};
        tbl[4]  = '{1, 0, 2'd3, 8'h00, 1, 16'(IRQB)};
        tbl[5]  = '{1, 1, 2'd3, 8'h00, 1, 16'(IRQB)};
        tbl[6]  = '{1, 0, 2'd3, 8'h00, 1, 16'h0000};
        tbl[7]  = '{1, 1, 2'd0, 8'h30, 1, 16'h0000};
        tbl[8]  = '{1, 0, 2'd2, 8'h00, 1, 16'h0010};
        tbl[9]  = '{1, 0, 2'd2, 8'h00, 1, 16'h0003};
        tbl[10] = '{1, 1, 2'd1, 8'h41, 1, 16'h0000};
        tbl[11] = '{1, 1, 2'd1, 8'h42, 1, 16'h0000};
        tbl[12] = '{1, 1, 2'd1, 8'h43, 1, 16'h0000};
        tbl[13] = '{1, 1, 2'd1, 8'h44, 1, 16'h0000};
        tbl[14] = '{1, 0, 2'd2, 8'h00, 1, 16'h0045};
        tbl[15] = '{1, 1, 2'd1, 8'h45, 1, 16'h0000};
        tbl[16] = '{1, 0, 2'd2, 8'h00, 1, 16'h004D};
        tbl[17] = '{1, 1, 2'd3, 8'h04, 1, 16'h0000};
        tbl[18] = '{1, 0, 2'd2, 8'h00, 1, 16'h0045};
        tbl[19] = '{1, 1, 2'd3, 8'h02, 1, 16'h0000};
        tbl[20] = '{1, 0, 2'd2, 8'h00, 1, 16'h0003};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            chipselect = tbl[i].cs;
            write_n    = !tbl[i].wr;
            address    = tbl[i].a;
            writedata  = tbl[i].wd;
            #1;
            if (tbl[i].en) chk($sformatf("tbl_row%0d", i), 32'(readdata), 32'(tbl[i].exp));
            @(posedge clk); #1;
        end
        idle_raw(60);
        chk("tbl_flush_pulses", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) chk("tbl_flush_byte", 32'({obs_q[0].rs, obs_q[0].d}), 32'h030);
        read_status("tbl_after_flush", 16'h0002);

        // Basic char timing and back-to-back period
        do_reset();
        tick(1, 1, 8'h41, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) tick(1, 1, 8'h51, 0, 0);
            else        tick(0, 0, 8'h00, 0, 0);
            chk($sformatf("a_e_k%0d", k), 32'(lcd_e), 32'(k >= 3 && k <= 6));
            chk("a_rsdata", 32'({lcd_rs, lcd_data}), 32'h141);
        end
        repeat (40) tick(0, 0, 8'h00, 0, 0);
        compare_xfers("a");
        if (obs_q.size() >= 2) chk("a_period", 32'(obs_q[1].c - obs_q[0].c), 32'(1 + S + PU + H + G));
        else chk("a_period", 32'(obs_q.size()), 32'd2);

        // Clear command followed by a character: long settle before the next strobe
        do_reset();
        tick(1, 0, 8'h01, 0, 0);
        tick(1, 1, 8'h42, 0, 0);
        repeat (110) tick(0, 0, 8'h00, 0, 0);
        compare_xfers("b");
        if (obs_q.size() >= 2) chk("b_long_period", 32'(obs_q[1].c - obs_q[0].c), 32'(1 + S + PU + H + LG));
        else chk("b_long_period", 32'(obs_q.size()), 32'd2);

        // Randomized traffic with STATUS reads and overflow clears
        do_reset();
        for (int k = 0; k < 700; k++) begin
            int r;
            bit rs;
            bit [7:0] d;
            r  = int'($urandom_range(0, 99));
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            if (!rs && $urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
            if (r < 12)      tick(1, rs, d, 0, 0);
            else if (r < 15) tick(0, 0, 8'h00, 0, 1);
            else             tick(0, 0, 8'h00, 1, 0);
        end
        for (int k = 0; k < 400 && (mq.size() > 0 || cyc <= next_free + 2); k++)
            tick(0, 0, 8'h00, 1, 0);
        compare_xfers("rnd");

        // Flush while the first byte is strobing, three bytes queued behind it
        do_reset();
        wr_raw(2'd1, 8'h61);
        wr_raw(2'd1, 8'h62);
        wr_raw(2'd1, 8'h63);
        wr_raw(2'd1, 8'h64);
        for (int k = 0; k < 20 && !lcd_e; k++) idle_raw(1);
        chk("c_e_seen", 32'(lcd_e), 32'd1);
        wr_raw(2'd3, 8'h02);
        idle_raw(60);
        chk("c_pulses", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) chk("c_byte", 32'({obs_q[0].rs, obs_q[0].d}), 32'h161);
        read_status("c_status", 16'h0002);

        // Drain-complete interrupt
        do_reset();
        begin
            int w;
            int t_on;
            wr_raw(2'd3, 8'h01);
            idle_raw(2);
            chk("irq_idle_en", 32'(irq), 32'(IRQB));
            wr_raw(2'd1, 8'h48);
            w = cyc;
            wr_raw(2'd1, 8'h49);
            t_on = w + 1 + 2 * (1 + S + PU + H + G);
            for (int k = 0; k < 50; k++) begin
                chk("irq_drain", 32'(irq), 32'(IRQB && cyc >= t_on));
                idle_raw(1);
            end
            wr_raw(2'd3, 8'h00);
        end

        // Reset asserted mid-strobe
        do_reset();
        wr_raw(2'd1, 8'h55);
        for (int k = 0; k < 20 && !lcd_e; k++) idle_raw(1);
        chk("e_seen", 32'(lcd_e), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("e_async_drop", 32'(lcd_e), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        read_status("e_status", 16'h0002);
        chk("e_outputs", 32'({lcd_e, lcd_rs, lcd_rw, irq, lcd_data}), 32'h0);
        @(posedge clk); #1;
        obs_q.delete();
        idle_raw(30);
        chk("e_no_resume", 32'(obs_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
